// File: rtl/pipe_stage_elastic_pkg.sv
// Shared types for the elastic pipeline-stage register.
// Occupancy encoding and a small helper used by the stage top.
package pipe_stage_elastic_pkg;

  typedef logic [1:0] lc3b_pipe_occ;

  localparam lc3b_pipe_occ OCC_EMPTY = 2'd0;
  localparam lc3b_pipe_occ OCC_MAIN  = 2'd1;
  localparam lc3b_pipe_occ OCC_FULL  = 2'd2;

  function automatic lc3b_pipe_occ occ_count(
    input logic main_v,
    input logic skid_v
  );
    return {1'b0, main_v} + {1'b0, skid_v};
  endfunction

endpackage

// File: rtl/pipe_stage_elastic_entry.sv
// One storage entry: valid bit, control word and payload.
// Load writes a beat (or a bubble); flush squashes; reset zeroes all.
module pipe_entry
  import pipe_stage_elastic_pkg::*;
#(
  parameter int CTRL_W     = 16,
  parameter int DATA_W     = 64,
  parameter int CLEAR_DATA = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              load,
  input  logic              v_in,
  input  logic [CTRL_W-1:0] ctrl_in,
  input  logic [DATA_W-1:0] data_in,
  output logic              valid,
  output logic [CTRL_W-1:0] ctrl,
  output logic [DATA_W-1:0] data
);

  logic              valid_q, valid_d;
  logic [CTRL_W-1:0] ctrl_q, ctrl_d;
  logic [DATA_W-1:0] data_q, data_d;

  always_comb begin
    valid_d = valid_q;
    ctrl_d  = ctrl_q;
    data_d  = data_q;
    if (flush) begin
      valid_d = 1'b0;
      ctrl_d  = '0;
      if (CLEAR_DATA != 0) data_d = '0;
    end else if (load) begin
      valid_d = v_in;
      if (v_in) begin
        ctrl_d = ctrl_in;
        data_d = data_in;
      end else begin
        ctrl_d = '0;
        if (CLEAR_DATA != 0) data_d = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 1'b0;
      ctrl_q  <= '0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      ctrl_q  <= ctrl_d;
      data_q  <= data_d;
    end
  end

  assign valid = valid_q;
  assign ctrl  = ctrl_q;
  assign data  = data_q;

endmodule

// File: rtl/pipe_stage_elastic.sv
// Elastic pipeline-stage register with optional skid entry.
// Empty stage shows ctrl=0 so downstream sees a NOP bubble.
module pipe_stage_elastic
  import pipe_stage_elastic_pkg::*;
#(
  parameter int CTRL_W     = 16,
  parameter int DATA_W     = 64,
  parameter int SKID       = 1,
  parameter int CLEAR_DATA = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy
);

  logic              main_v, skid_v;
  logic [CTRL_W-1:0] main_ctrl, skid_ctrl;
  logic [DATA_W-1:0] main_data, skid_data;
  logic              acc, cons;
  logic              main_load, main_vin;
  logic [CTRL_W-1:0] main_ctrl_in;
  logic [DATA_W-1:0] main_data_in;

  assign acc  = in_valid && in_ready && !flush;
  assign cons = main_v && out_ready && !flush;

  // A held skid beat always refills main ahead of any new input.
  always_comb begin
    main_load    = cons || (acc && !main_v);
    main_vin     = skid_v || acc;
    main_ctrl_in = skid_v ? skid_ctrl : in_ctrl;
    main_data_in = skid_v ? skid_data : in_data;
  end

  pipe_entry #(
    .CTRL_W    (CTRL_W),
    .DATA_W    (DATA_W),
    .CLEAR_DATA(CLEAR_DATA)
  ) u_main (
    .clk    (clk),
    .reset  (reset),
    .flush  (flush),
    .load   (main_load),
    .v_in   (main_vin),
    .ctrl_in(main_ctrl_in),
    .data_in(main_data_in),
    .valid  (main_v),
    .ctrl   (main_ctrl),
    .data   (main_data)
  );

  if (SKID == 1) begin : g_skid
    logic skid_load;
    assign skid_load = (acc && main_v && !cons) || (skid_v && cons);

    pipe_entry #(
      .CTRL_W    (CTRL_W),
      .DATA_W    (DATA_W),
      .CLEAR_DATA(CLEAR_DATA)
    ) u_skid (
      .clk    (clk),
      .reset  (reset),
      .flush  (flush),
      .load   (skid_load),
      .v_in   (acc),
      .ctrl_in(in_ctrl),
      .data_in(in_data),
      .valid  (skid_v),
      .ctrl   (skid_ctrl),
      .data   (skid_data)
    );

    assign in_ready = !skid_v;
  end else begin : g_noskid
    assign skid_v    = 1'b0;
    assign skid_ctrl = '0;
    assign skid_data = '0;
    assign in_ready  = out_ready || !main_v;
  end

  assign out_valid = main_v;
  assign out_ctrl  = main_v ? main_ctrl : '0;
  assign out_data  = (CLEAR_DATA != 0 && !main_v) ? '0 : main_data;
  assign occupancy = occ_count(main_v, skid_v);

  a_hold: assert property (@(posedge clk) disable iff (reset)
    (in_valid && !in_ready && !flush) |=>
    (in_valid && $stable(in_ctrl) && $stable(in_data)));

  a_occ: assert property (@(posedge clk) disable iff (reset)
    occupancy != 2'd3);

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// Bench for pipe_stage_elastic: table vectors, corner sequences,
// and a random valid/ready/flush run against a queue model.
module tb_pipe_stage_elastic;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic        f1, iv1, or1, ir1, ov1;
  logic [15:0] ic1, oc1;
  logic [63:0] id1, od1;
  logic [1:0]  occ1;

  logic        f0, iv0, or0, ir0, ov0;
  logic [15:0] ic0, oc0;
  logic [63:0] id0, od0;
  logic [1:0]  occ0;

  pipe_stage_elastic #(
    .CTRL_W(16), .DATA_W(64), .SKID(1), .CLEAR_DATA(0)
  ) u_dut (
    .clk(clk), .reset(reset), .flush(f1),
    .in_valid(iv1), .in_ready(ir1),
    .in_ctrl(ic1), .in_data(id1),
    .out_valid(ov1), .out_ready(or1),
    .out_ctrl(oc1), .out_data(od1),
    .occupancy(occ1)
  );

  pipe_stage_elastic #(
    .CTRL_W(16), .DATA_W(64), .SKID(0), .CLEAR_DATA(1)
  ) u_dut0 (
    .clk(clk), .reset(reset), .flush(f0),
    .in_valid(iv0), .in_ready(ir0),
    .in_ctrl(ic0), .in_data(id0),
    .out_valid(ov0), .out_ready(or0),
    .out_ctrl(oc0), .out_data(od0),
    .occupancy(occ0)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [63:0] data_of(input logic [15:0] c);
    return {c, ~c, c ^ 16'h5A5A, 16'hC0DE};
  endfunction

  typedef struct {
    logic        fl;
    logic        iv;
    logic [15:0] c;
    logic        rdy;
    logic        ev;
    logic [15:0] ec;
    logic [1:0]  eo;
    logic        eir;
  } vec_t;

  typedef struct {
    logic [15:0] c;
    logic [63:0] d;
  } beat_t;

  vec_t  tv[$];
  beat_t q[$];

  task automatic add(input int fl, iv, c, rdy, ev, ec, eo, eir);
    vec_t v;
    v.fl  = fl[0];
    v.iv  = iv[0];
    v.c   = c[15:0];
    v.rdy = rdy[0];
    v.ev  = ev[0];
    v.ec  = ec[15:0];
    v.eo  = eo[1:0];
    v.eir = eir[0];
    tv.push_back(v);
  endtask

  initial begin
    beat_t cur;
    logic  cur_v;
    logic  acc, cons;

    reset = 1'b1;
    {f1, iv1, or1, ic1, id1} = '0;
    {f0, iv0, or0, ic0, id0} = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rst_valid", ov1, 0);
    chk("rst_ctrl", oc1, 0);
    chk("rst_occ", occ1, 0);
    chk("rst_ready", ir1, 1);
    chk("rst_data", od1, 0);
    chk("rst0_valid", ov0, 0);
    chk("rst0_ready", ir0, 1);

    for (int i = 1; i <= 8; i++) add(0, 1, i, 1, 1, i, 1, 1);
    add(0, 0, 0, 1, 0, 0, 0, 1);
    add(0, 1, 'hA, 0, 1, 'hA, 1, 1);
    add(0, 1, 'hB, 0, 1, 'hA, 2, 0);
    add(0, 1, 'hC, 0, 1, 'hA, 2, 0);
    add(0, 1, 'hC, 1, 1, 'hB, 1, 1);
    add(0, 1, 'hC, 1, 1, 'hC, 1, 1);
    add(0, 0, 0, 1, 0, 0, 0, 1);
    add(0, 1, 'h11, 0, 1, 'h11, 1, 1);
    add(0, 1, 'h12, 0, 1, 'h11, 2, 0);
    add(1, 1, 'hD, 1, 0, 0, 0, 1);
    add(0, 0, 0, 1, 0, 0, 0, 1);
    add(1, 1, 'hE, 1, 0, 0, 0, 1);
    add(0, 0, 0, 1, 0, 0, 0, 1);

    foreach (tv[i]) begin
      @(negedge clk);
      f1  = tv[i].fl;
      iv1 = tv[i].iv;
      ic1 = tv[i].c;
      id1 = data_of(tv[i].c);
      or1 = tv[i].rdy;
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d_valid", i), ov1, tv[i].ev);
      chk($sformatf("vec%0d_ctrl", i), oc1, tv[i].ec);
      chk($sformatf("vec%0d_occ", i), occ1, tv[i].eo);
      chk($sformatf("vec%0d_ready", i), ir1, tv[i].eir);
      if (tv[i].ev)
        chk($sformatf("vec%0d_data", i), od1, data_of(tv[i].ec));
    end

    @(negedge clk);
    {f1, iv1, or1} = 3'b001;
    iv0 = 1'b1;
    ic0 = 16'h21;
    id0 = data_of(16'h21);
    or0 = 1'b0;
    @(posedge clk);
    #1;
    chk("s0_hold_valid", ov0, 1);
    chk("s0_hold_ctrl", oc0, 16'h21);
    chk("s0_hold_occ", occ0, 1);
    @(negedge clk);
    ic0 = 16'h22;
    id0 = data_of(16'h22);
    #1;
    chk("s0_stall_ready", ir0, 0);
    or0 = 1'b1;
    #1;
    chk("s0_comb_ready", ir0, 1);
    @(posedge clk);
    #1;
    chk("s0_swap_ctrl", oc0, 16'h22);
    chk("s0_swap_occ", occ0, 1);
    chk("s0_swap_data", od0, data_of(16'h22));
    @(negedge clk);
    iv0 = 1'b0;
    @(posedge clk);
    #1;
    chk("s0_drain_valid", ov0, 0);
    chk("s0_drain_ctrl", oc0, 0);
    chk("s0_drain_data", od0, 0);
    chk("s0_drain_occ", occ0, 0);

    @(negedge clk);
    iv1 = 1'b1;
    ic1 = 16'h31;
    id1 = data_of(16'h31);
    or1 = 1'b0;
    @(negedge clk);
    ic1 = 16'h32;
    id1 = data_of(16'h32);
    @(negedge clk);
    ic1 = 16'h33;
    id1 = data_of(16'h33);
    #1;
    chk("t6_full_ready", ir1, 0);
    chk("t6_full_occ", occ1, 2);
    reset = 1'b1;
    f1 = 1'b1;
    @(posedge clk);
    #1;
    chk("t6_valid", ov1, 0);
    chk("t6_ctrl", oc1, 0);
    chk("t6_data", od1, 0);
    chk("t6_occ", occ1, 0);
    chk("t6_ready", ir1, 1);
    @(negedge clk);
    reset = 1'b0;
    {f1, iv1, or1} = 3'b000;

    cur_v = 1'b0;
    cur.c = '0;
    cur.d = '0;
    for (int n = 0; n < 600; n++) begin
      @(negedge clk);
      chk("rnd_valid", ov1, q.size() > 0);
      chk("rnd_ctrl", oc1, q.size() > 0 ? q[0].c : 16'h0);
      chk("rnd_occ", occ1, q.size());
      chk("rnd_ready", ir1, q.size() < 2);
      if (q.size() > 0) chk("rnd_data", od1, q[0].d);
      if (!cur_v && $urandom_range(0, 3) != 0) begin
        cur_v = 1'b1;
        cur.c = 16'($urandom_range(1, 16'hFFFF));
        cur.d = {$urandom, $urandom};
      end
      iv1 = cur_v;
      ic1 = cur.c;
      id1 = cur.d;
      or1 = $urandom_range(0, 3) != 0;
      f1  = $urandom_range(0, 19) == 0;
      acc  = cur_v && q.size() < 2 && !f1;
      cons = q.size() > 0 && or1 && !f1;
      @(posedge clk);
      if (f1) begin
        q.delete();
        cur_v = 1'b0;
      end else begin
        if (cons) void'(q.pop_front());
        if (acc) begin
          q.push_back(cur);
          cur_v = 1'b0;
        end
      end
    end

    @(negedge clk);
    {f1, iv1, or1} = 3'b000;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
